// File: rtl/ysyx_22041412_idu_if.sv
// Bundle between fetch, the decode/issue stage, execute and writeback.
// slave: the idu side; master: the surrounding pipeline (or a bench).
interface ysyx_22041412_idu_if;
  localparam int unsigned XLEN = 64;
  localparam int unsigned RW   = 5;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] scr1;
  logic [XLEN-1:0] scr2;
  logic [6:0]      opcode;
  logic [2:0]      func3;
  logic            func7;
  logic [RW-1:0]   rd;
  logic            rd_wen;
  logic [XLEN-1:0] st_data;
  logic            wb_en;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  modport slave (
    input  in_valid, inst, pc, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, scr1, scr2, opcode, func3, func7, rd, rd_wen, st_data
  );

  modport master (
    output in_valid, inst, pc, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, scr1, scr2, opcode, func3, func7, rd, rd_wen, st_data
  );
endinterface

// File: rtl/ysyx_22041412_idu.sv
// RV64I decode/issue stage: register file, busy scoreboard, issue register.
// Optional macro YSYX_22041412_WB_BYPASS_EN forwards same-cycle writeback
// data into operand reads and the hazard check.
module ysyx_22041412_idu (
  input logic                 clk,
  input logic                 rst_n,
  ysyx_22041412_idu_if.slave  io
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned RW   = 5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_R64   = 7'b0111011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_I64   = 7'b0011011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt_c;
  logic [NREG-1:0] busy_eff_c;

  logic [6:0]      op_c;
  logic [RW-1:0]   rs1_c, rs2_c, rdi_c;
  logic [XLEN-1:0] rs1_val_c, rs2_val_c;
  logic [XLEN-1:0] imm_i_c, imm_s_c, imm_u_c;
  logic [XLEN-1:0] scr1_c, scr2_c, st_data_c;
  logic            use_rs1_c, use_rs2_c, wr_rd_c, rd_wen_c;
  logic            hazard_c, accept_c;

  assign op_c    = io.inst[6:0];
  assign rs1_c   = io.inst[19:15];
  assign rs2_c   = io.inst[24:20];
  assign rdi_c   = io.inst[11:7];
  assign imm_i_c = {{(XLEN-12){io.inst[31]}}, io.inst[31:20]};
  assign imm_s_c = {{(XLEN-12){io.inst[31]}}, io.inst[31:25], io.inst[11:7]};
  assign imm_u_c = {{(XLEN-32){io.inst[31]}}, io.inst[31:12], 12'h000};

  // Register file read ports (x0 hard-wired to zero, optional writeback bypass)
  always_comb begin
    rs1_val_c = (rs1_c == '0) ? '0 : regs[rs1_c];
    rs2_val_c = (rs2_c == '0) ? '0 : regs[rs2_c];
`ifdef YSYX_22041412_WB_BYPASS_EN
    if (io.wb_en && (io.wb_rd != '0) && (io.wb_rd == rs1_c)) rs1_val_c = io.wb_data;
    if (io.wb_en && (io.wb_rd != '0) && (io.wb_rd == rs2_c)) rs2_val_c = io.wb_data;
`endif
  end

  // Busy view used for hazards; a landing writeback may release its bit early
  always_comb begin
    busy_eff_c = busy;
`ifdef YSYX_22041412_WB_BYPASS_EN
    if (io.wb_en && (io.wb_rd != '0)) busy_eff_c[io.wb_rd] = 1'b0;
`endif
  end

  // Opcode decode: operand selection and register usage
  always_comb begin
    use_rs1_c = 1'b0;
    use_rs2_c = 1'b0;
    wr_rd_c   = 1'b0;
    scr1_c    = '0;
    scr2_c    = '0;
    st_data_c = '0;
    case (op_c)
      OP_R, OP_R64: begin
        use_rs1_c = 1'b1;
        use_rs2_c = 1'b1;
        wr_rd_c   = 1'b1;
        scr1_c    = rs1_val_c;
        scr2_c    = rs2_val_c;
      end
      OP_I, OP_I64, OP_LOAD: begin
        use_rs1_c = 1'b1;
        wr_rd_c   = 1'b1;
        scr1_c    = rs1_val_c;
        scr2_c    = imm_i_c;
      end
      OP_STORE: begin
        use_rs1_c = 1'b1;
        use_rs2_c = 1'b1;
        scr1_c    = rs1_val_c;
        scr2_c    = imm_s_c;
        st_data_c = rs2_val_c;
      end
      OP_AUIPC: begin
        wr_rd_c = 1'b1;
        scr1_c  = io.pc;
        scr2_c  = imm_u_c;
      end
      OP_LUI: begin
        wr_rd_c = 1'b1;
        scr2_c  = imm_u_c;
      end
      default: ;
    endcase
  end

  assign rd_wen_c = wr_rd_c && (rdi_c != '0);
  assign hazard_c = (use_rs1_c && busy_eff_c[rs1_c]) ||
                    (use_rs2_c && busy_eff_c[rs2_c]) ||
                    (rd_wen_c  && busy_eff_c[rdi_c]);
  assign io.in_ready = !hazard_c && (!io.out_valid || io.out_ready);
  assign accept_c    = io.in_valid && io.in_ready;

  // Scoreboard next state: writeback clears, issue sets, set wins on collision
  always_comb begin
    busy_nxt_c = busy;
    if (io.wb_en) busy_nxt_c[io.wb_rd] = 1'b0;
    if (accept_c && rd_wen_c) busy_nxt_c[rdi_c] = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt_c;
  end

  // Register file write port, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (io.wb_en && (io.wb_rd != '0)) begin
      regs[io.wb_rd] <= io.wb_data;
    end
  end

  // Issue register toward execute: loads on accept, holds while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.scr1      <= '0;
      io.scr2      <= '0;
      io.st_data   <= '0;
      io.opcode    <= '0;
      io.func3     <= '0;
      io.func7     <= 1'b0;
      io.rd        <= '0;
      io.rd_wen    <= 1'b0;
    end else if (accept_c) begin
      io.out_valid <= 1'b1;
      io.scr1      <= scr1_c;
      io.scr2      <= scr2_c;
      io.st_data   <= st_data_c;
      io.opcode    <= op_c;
      io.func3     <= io.inst[14:12];
      io.func7     <= io.inst[30];
      io.rd        <= rdi_c;
      io.rd_wen    <= rd_wen_c;
    end else if (io.out_ready) begin
      io.out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/ysyx_22041412_idu.md
# ysyx_22041412_idu

Decode/issue stage feeding the execute ALU. It accepts a 32-bit RV64I instruction with its PC and decodes it. It reads and writes back a 32×64 integer register file, with a scoreboard that blocks RAW/WAW hazards. It delivers registered operands (scr1, scr2, opcode, func3, func7) to the ALU through a valid/ready pipeline register.

## Interface
Parameters
- none (widths fixed: XLEN 64, 32 registers)

Ports
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  idu accepts instruction this cycle
- inst  in  32  instruction word
- pc  in  64  instruction address
- out_valid  out  1  issue register holds an instruction
- out_ready  in  1  execute consumes issue register this cycle
- scr1  out  64  ALU operand 1
- scr2  out  64  ALU operand 2
- opcode  out  7  inst[6:0]
- func3  out  3  inst[14:12]
- func7  out  1  inst[30]
- rd  out  5  destination register
- rd_wen  out  1  instruction writes rd (rd≠0)
- st_data  out  64  rs2 value for stores
- wb_en  in  1  writeback valid
- wb_rd  in  5  writeback register
- wb_data  in  64  writeback value

## Operation
- Decode, by opcode:
  - R (0110011), RV64_R (0111011): scr1=x[rs1], scr2=x[rs2].
  - I (0010011), RV64_I (0011011), load (0000011): scr1=x[rs1], scr2=sext(inst[31:20]).
  - store (0100011): scr1=x[rs1], scr2=sext({inst[31:25],inst[11:7]}), st_data=x[rs2].
  - auipc (0010111): scr1=pc, scr2=sext({inst[31:12],12'b0}).
  - lui (0110111): scr1=0, scr2=sext({inst[31:12],12'b0}).
  - any other opcode: scr1=scr2=0, rd_wen=0; opcode/func3/func7 still passed through.
- rd_wen=1 for R, RV64_R, I, RV64_I, load, auipc, lui when rd≠0; 0 otherwise.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Write when wb_en; read is combinational from current contents.
- Scoreboard: 32-bit busy vector.
  - On accept with rd_wen: busy[rd] set.
  - On wb_en: busy[wb_rd] cleared.
  - Set and clear of the same bit in the same cycle: set wins.
- Hazard (in_ready forced 0) when any of these holds:
  - rs1 is used and busy[rs1];
  - rs2 is used (R, RV64_R, store) and busy[rs2];
  - rd_wen and busy[rd].
- Operands are never forwarded from ALU output; hazards resolve only via writeback.

## Timing
- in_ready = !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept, the issue register loads at the next edge: latency 1 cycle.
- out_valid and all output fields hold stable while out_valid && !out_ready.
- out_valid clears at the edge where out_ready=1 and nothing is accepted. Back-to-back accept with out_ready=1 sustains 1 instruction/cycle.
- Writeback in cycle N is visible to reads in cycle N+1. The scoreboard bit drops at the edge ending cycle N.
- Reset (rst_n=0 at an edge), including mid-stall or with out_valid=1:
  - out_valid=0, busy vector=0, all register file entries=0;
  - scr1, scr2, st_data=0; opcode, func3, func7, rd, rd_wen=0;
  - any in-flight instruction is dropped.

## Configuration
- YSYX_22041412_WB_BYPASS_EN defined:
  - a same-cycle writeback (wb_en, wb_rd≠0) matching rs1/rs2 supplies wb_data as the read value;
  - the matching busy bit is treated as clear for the hazard check, so a dependent instruction issues in the writeback cycle.
- Undefined: no bypass. The dependent instruction issues the cycle after writeback.

## Test plan
- Reset then addi x1,x0,5 (0x00500093), out_ready=1 → next cycle out_valid=1, scr1=0, scr2=5, opcode=0010011, rd=1, rd_wen=1, busy[1]=1.
- add x2,x1,x1 behind it, no writeback → in_ready=0 until wb_en,wb_rd=1,wb_data=5. Then scr1=scr2=5: issued one cycle later without bypass, same cycle with YSYX_22041412_WB_BYPASS_EN.
- lui x3,0x80000 at pc=0x80000000 → scr2=0xFFFFFFFF80000000. auipc x4,1 → scr1=0x80000000, scr2=0x1000.
- sd x5,-8(x6) with x5=0x1234, x6=0x100 → scr1=0x100, scr2=0xFFFFFFFFFFFFFFF8, st_data=0x1234, rd_wen=0.
- out_ready=0 for 3 cycles with in_valid=1 → outputs held constant, in_ready=0, no busy change. Release → one issue per cycle.
- Assert rst_n=0 while out_valid=1 and busy[7]=1 → next cycle out_valid=0, busy=0, x7 reads 0.
